// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, types and the hex decode table
// for the seven-segment scan driver.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Active-low, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic dot;
    logic blank;
    logic flash;
  } slot_attr_t;

  function automatic logic [6:0] hex2seg(
    input logic [3:0] v
  );
    return HEX_SEG[v];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational 4-bit hex to
// active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex2seg(hex_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode display scanner with
// dead-time, flash/blank masks; PWM brightness when SEG7_PWM_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 262144,
  parameter int FLASH_DIV    = 67108864,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   flash_mask,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW =
    (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int SW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_L =
    CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FL_LAST =
    FW'(FLASH_DIV - 1);
  localparam logic [SW-1:0] SEL_LAST =
    SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF =
    AN_OFF[NUM_DIGITS-1:0];

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  flash_q, flash_d;
  slot_attr_t            attr_q, attr_d;
  slot_attr_t            attr_live;
  logic [3:0]            nib_live;
  logic [6:0]            seg_dec;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  slot_start;
  logic                  slot_end;
  logic                  win_next;
  logic                  pwm_ok;
  logic                  an_en;

  assign slot_start = (cnt_q == '0);
  assign slot_end   = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    sel_d = sel_q;
    if (slot_end) begin
      if (sel_q == '0) sel_d = SEL_LAST;
      else             sel_d = sel_q - 1'b1;
    end
  end

  always_comb begin
    fcnt_d  = fcnt_q + 1'b1;
    flash_d = flash_q;
    if (fcnt_q == FL_LAST) begin
      fcnt_d  = '0;
      flash_d = ~flash_q;
    end
  end

  always_comb begin
    nib_live  = '0;
    attr_live = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (SW'(i) == sel_q) begin
        nib_live        = digits[4*i +: 4];
        attr_live.dot   = dots[i];
        attr_live.blank = blank[i];
        attr_live.flash = flash_mask[i];
      end
    end
  end

  seg7_hex_decode u_dec (
    .hex_i (nib_live),
    .seg_o (seg_dec)
  );

`ifdef SEG7_PWM_EN
  logic [BRIGHT_W-1:0] pwm_q, pwm_d;

  assign pwm_d  = pwm_q + 1'b1;
  // All-ones brightness must mean fully on, not 15/16.
  assign pwm_ok = (&brightness) ||
                  (pwm_d < brightness);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= '0;
    else        pwm_q <= pwm_d;
  end
`else
  logic unused_bright;

  assign unused_bright = ^brightness;
  assign pwm_ok        = 1'b1;
`endif

  // The snapshot is taken at slot start, so use the
  // live attributes in that cycle and the held copy after.
  assign attr_d   = slot_start ? attr_live : attr_q;
  assign win_next = (cnt_d >= BLANK_L);
  assign an_en    = win_next &&
                    !attr_d.blank &&
                    !(attr_d.flash && flash_d) &&
                    pwm_ok;

  always_comb begin
    an_d = AN_ALL_OFF;
    if (an_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (SW'(i) == sel_q) an_d[i] = 1'b0;
      end
    end
    dp_d  = !(attr_d.dot && an_en);
    seg_d = slot_start ? seg_dec : seg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sel_q   <= SEL_LAST;
      fcnt_q  <= '0;
      flash_q <= 1'b0;
      attr_q  <= '0;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      an_q    <= AN_ALL_OFF;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      fcnt_q  <= fcnt_d;
      flash_q <= flash_d;
      attr_q  <= attr_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; stimulus queues one
// expected record per scan slot, a monitor checks every cycle.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int FD    = 64;
  localparam int BC    = 2;
  localparam int BW    = 4;
  localparam int NSLOT = 25;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dot;
    logic [3:0] bright;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits;
  logic [3:0]    dots;
  logic [3:0]    blank;
  logic [3:0]    flash_mask;
  logic [BW-1:0] brightness;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_done = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .FLASH_DIV    (FD),
    .BLANK_CYCLES (BC),
    .BRIGHT_W     (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .dots       (dots),
    .blank      (blank),
    .flash_mask (flash_mask),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic push_exp(input int s);
    exp_t       r;
    int         d;
    logic [15:0] dg;
    logic [3:0] nib;
    logic       fl;
    d   = 3 - (s % 4);
    dg  = digits;
    nib = dg[4*d +: 4];
    fl  = ((s / 8) % 2) == 1;
    r.an = 4'hF;
    if (!(blank[d] || (flash_mask[d] && fl)))
      r.an = ~(4'b0001 << d);
    r.seg    = HEX[nib];
    r.dot    = dots[d];
    r.bright = brightness;
    sbq.push_back(r);
  endtask

  task automatic apply_slot(input int s);
    case (s)
      8: begin
        digits = 16'h90E7;
        blank  = 4'b1000;
        dots   = 4'b1000;
      end
      12: begin
        digits = 16'h5F68;
        blank  = 4'b0000;
        dots   = 4'b0001;
      end
      16: begin
        digits     = 16'hC0DE;
        dots       = 4'b0000;
        brightness = 4'h4;
      end
      20: begin
        digits     = 16'h7B3A;
        brightness = 4'hF;
      end
      24: digits = 16'h2468;
      default: ;
    endcase
  endtask

  initial begin : monitor
    exp_t       r;
    logic       on;
    logic       gate;
    logic [3:0] ea;
    logic       ed;
    r = '{4'hF, 7'h7F, 1'b0, 4'hF};
    wait (rst_n === 1'b1);
    for (int c = 0; c < NSLOT * SD; c++) begin
      @(negedge clk);
      if (c % SD == 1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sbq_empty: cycle %0d", c);
        end else begin
          r = sbq.pop_front();
        end
      end
      if (c % SD < BC) begin
        chk($sformatf("dead_an c%0d", c),
            16'(an), 16'hF);
        if (c % SD == 1)
          chk($sformatf("dead_seg c%0d", c),
              16'(seg), 16'(r.seg));
      end else begin
`ifdef SEG7_PWM_EN
        gate = (r.bright == 4'hF) ||
               ((c % 16) < int'(r.bright));
`else
        gate = 1'b1;
`endif
        on = (r.an != 4'hF) && gate;
        ea = on ? r.an : 4'hF;
        ed = !(r.dot && on);
        chk($sformatf("win c%0d {an,seg,dp}", c),
            16'({an, seg, dp}),
            16'({ea, r.seg, ed}));
      end
    end
    mon_done = 1'b1;
  end

  initial begin : stim
    int cur;
    rst_n      = 1'b0;
    digits     = 16'h1234;
    dots       = 4'b0000;
    blank      = 4'b0000;
    flash_mask = 4'b0010;
    brightness = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",  16'(an),  16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp",  16'(dp),  16'h1);
    cur = 0;
    for (int s = 0; s < NSLOT; s++) begin
      if (s > 0) begin
        repeat (SD * s - cur) @(posedge clk);
        #1;
        cur = SD * s;
      end
      apply_slot(s);
      if (s == 0) rst_n = 1'b1;
      push_exp(s);
      if (s == 4) begin
        repeat (3) @(posedge clk);
        #1;
        cur += 3;
        digits = 16'hABCD;
      end
    end
    repeat (SD * NSLOT + 4 - cur) @(posedge clk);
    #3;
    chk("pre_rst_an",  16'(an),  16'b1011);
    chk("pre_rst_seg", 16'(seg), 16'h19);
    rst_n = 1'b0;
    #1;
    chk("async_an",  16'(an),  16'hF);
    chk("async_seg", 16'(seg), 16'h7F);
    chk("async_dp",  16'(dp),  16'h1);
    if (!mon_done) begin
      checks++;
      errors++;
      $display("FAIL monitor_done: monitor still running");
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sbq_left: %0d records", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

endmodule
